// File: rtl/vtx_csr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vtx_csr_pkg
// Description : Shared register offsets and bit indices for the video-TX
//               layer CSR block.
// Revision    : 1.0 - initial release
// ============================================================================
package vtx_csr_pkg;

    localparam int unsigned c_OFS_CTRL       = 'h000;
    localparam int unsigned c_OFS_STATUS     = 'h004;
    localparam int unsigned c_OFS_IRQEN      = 'h008;
    localparam int unsigned c_OFS_FRAMECNT   = 'h00C;
    localparam int unsigned c_OFS_LAYER_BASE = 'h100;
    localparam int unsigned c_LAYER_STRIDE   = 'h010;

    // Register index within one layer slot (offset bits [3:2])
    localparam logic [1:0] c_LREG_ADRSA = 2'd0;
    localparam logic [1:0] c_LREG_ADRSB = 2'd1;
    localparam logic [1:0] c_LREG_LEN   = 2'd2;
    localparam logic [1:0] c_LREG_LCTRL = 2'd3;

    localparam int unsigned c_ST_FRAME     = 0;
    localparam int unsigned c_ST_COMMITTED = 1;
    localparam int unsigned c_ST_UNDERFLOW = 2;
    localparam int unsigned c_ST_WIDTH     = 3;

    localparam int unsigned c_LC_EN   = 0;
    localparam int unsigned c_LC_SWAP = 1;

    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_PENDING = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vtx_layer_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vtx_layer_regs
// Description : One frame-buffer layer: shadow set, active set, ping-pong
//               buffer select and the layer's read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module vtx_layer_regs
    import vtx_csr_pkg::*;
#(
    parameter int unsigned LAYER_IDX    = 0,
    parameter int unsigned LAYER_NUM    = 2,
    parameter int unsigned MEM_W        = 19,
    parameter int unsigned CSR_W        = 16,
    parameter int unsigned FBUF_DEF_LEN = 130560
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CSR_W-1:0] offset,
    input  logic [31:0]      wdata,
    input  logic             frame_start,
    input  logic             commit,
    output logic [31:0]      rd_data,
    output logic             layer_en,
    output logic [MEM_W-1:0] layer_adrs,
    output logic [MEM_W-1:0] layer_len
);

    localparam logic [63:0] c_RST_A64   = 64'(LAYER_IDX) * 64'(FBUF_DEF_LEN);
    localparam logic [63:0] c_RST_B64   = 64'(LAYER_IDX + LAYER_NUM) * 64'(FBUF_DEF_LEN);
    localparam logic [63:0] c_RST_LEN64 = 64'(FBUF_DEF_LEN) - 64'd1;
    localparam logic [MEM_W-1:0] c_RST_A   = c_RST_A64[MEM_W-1:0];
    localparam logic [MEM_W-1:0] c_RST_B   = c_RST_B64[MEM_W-1:0];
    localparam logic [MEM_W-1:0] c_RST_LEN = c_RST_LEN64[MEM_W-1:0];
    localparam logic [CSR_W-5:0] c_SLOT =
        (CSR_W-4)'((c_OFS_LAYER_BASE + LAYER_IDX * c_LAYER_STRIDE) >> 4);

    logic [MEM_W-1:0] r_sh_a, r_sh_b, r_sh_len;
    logic             r_sh_en, r_sh_swap;
    logic [MEM_W-1:0] r_ac_a, r_ac_b, r_ac_len;
    logic             r_ac_en, r_ac_swap;
    logic             r_sel;
    logic [MEM_W-1:0] r_adrs;

    logic       w_hit;
    logic [1:0] w_reg;

    assign w_hit = (offset[CSR_W-1:4] == c_SLOT) && (offset[1:0] == 2'b00);
    assign w_reg = offset[3:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a    <= c_RST_A;
            r_sh_b    <= c_RST_B;
            r_sh_len  <= c_RST_LEN;
            r_sh_en   <= 1'b0;
            r_sh_swap <= 1'b0;
            r_ac_a    <= c_RST_A;
            r_ac_b    <= c_RST_B;
            r_ac_len  <= c_RST_LEN;
            r_ac_en   <= 1'b0;
            r_ac_swap <= 1'b0;
            r_sel     <= 1'b0;
            r_adrs    <= c_RST_A;
        end else begin
            if (wr_en && w_hit) begin
                case (w_reg)
                    c_LREG_ADRSA: r_sh_a   <= wdata[MEM_W-1:0];
                    c_LREG_ADRSB: r_sh_b   <= wdata[MEM_W-1:0];
                    c_LREG_LEN:   r_sh_len <= wdata[MEM_W-1:0];
                    default: begin
                        r_sh_en   <= wdata[c_LC_EN];
                        r_sh_swap <= wdata[c_LC_SWAP];
                    end
                endcase
            end
            // Active copy takes pre-edge shadow, so a same-cycle write stays shadow-only
            if (commit) begin
                r_ac_a    <= r_sh_a;
                r_ac_b    <= r_sh_b;
                r_ac_len  <= r_sh_len;
                r_ac_en   <= r_sh_en;
                r_ac_swap <= r_sh_swap;
                r_sel     <= 1'b0;
                r_adrs    <= r_sh_a;
            end else if (frame_start && r_ac_en && r_ac_swap) begin
                r_sel  <= ~r_sel;
                r_adrs <= r_sel ? r_ac_a : r_ac_b;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (w_hit) begin
            case (w_reg)
                c_LREG_ADRSA: rd_data = 32'(r_sh_a);
                c_LREG_ADRSB: rd_data = 32'(r_sh_b);
                c_LREG_LEN:   rd_data = 32'(r_sh_len);
                default: begin
                    rd_data[c_LC_EN]   = r_sh_en;
                    rd_data[c_LC_SWAP] = r_sh_swap;
                end
            endcase
        end
    end

    assign layer_en   = r_ac_en;
    assign layer_adrs = r_adrs;
    assign layer_len  = r_ac_len;

    if (MEM_W < 32) begin : g_unused_wd
        logic w_unused_wd;
        assign w_unused_wd = ^wdata[31:MEM_W];
    end

endmodule
`default_nettype wire

// File: rtl/vtx_layer_csr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vtx_layer_csr
// Description : Video-TX layer CSR: bus decode, global status/IRQ/frame
//               counter, frame-synchronous commit of per-layer shadow sets.
// Revision    : 1.0 - initial release
// ============================================================================
module vtx_layer_csr
    import vtx_csr_pkg::*;
#(
    parameter int unsigned pBlockAdrsMap = 8,
    parameter int unsigned pAdrsMap      = 'h04,
    parameter int unsigned pBusAdrsBit   = 32,
    parameter int unsigned pCsrAdrsWidth = 16,
    parameter int unsigned pMemAdrsWidth = 19,
    parameter int unsigned pLayerNum     = 2,
    parameter int unsigned pFbufDefLen   = 130560
)(
    input  logic                               iSysClk,
    input  logic                               iSysRst,
    input  logic [31:0]                        iSUsiWd,
    input  logic [pBusAdrsBit-1:0]             iSUsiAdrs,
    input  logic                               iSUsiWCke,
    output logic [31:0]                        oSUsiRd,
    output logic                               oSUsiREd,
    input  logic                               iFrameStart,
    input  logic                               iUnderflow,
    output logic [pLayerNum-1:0]               oLayerEn,
    output logic [pLayerNum*pMemAdrsWidth-1:0] oLayerAdrs,
    output logic [pLayerNum*pMemAdrsWidth-1:0] oLayerLen,
    output logic                               oIrq
);

    localparam int unsigned c_SEL_MSB = pBlockAdrsMap + pCsrAdrsWidth - 1;
    localparam logic [pBlockAdrsMap-1:0] c_BLK_SEL = pBlockAdrsMap'(pAdrsMap);
    localparam logic [pCsrAdrsWidth-1:0] c_CTRL    = pCsrAdrsWidth'(c_OFS_CTRL);
    localparam logic [pCsrAdrsWidth-1:0] c_STATUS  = pCsrAdrsWidth'(c_OFS_STATUS);
    localparam logic [pCsrAdrsWidth-1:0] c_IRQEN   = pCsrAdrsWidth'(c_OFS_IRQEN);
    localparam logic [pCsrAdrsWidth-1:0] c_FCNT    = pCsrAdrsWidth'(c_OFS_FRAMECNT);

    logic                     w_blk_hit;
    logic [pCsrAdrsWidth-1:0] w_ofs;
    logic                     w_wr;
    logic                     w_wr_ctrl, w_wr_status, w_wr_irqen;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  w_pending;
    logic                  w_commit;
    logic [c_ST_WIDTH-1:0] r_status;
    logic [c_ST_WIDTH-1:0] r_irqen;
    logic [c_ST_WIDTH-1:0] w_st_set, w_st_clr;
    logic [15:0]           r_fcnt;
    logic                  r_irq;
    logic [31:0]           r_rd;
    logic                  r_red;
    logic [31:0]           w_rd_glb, w_rd_lyr;
    logic [31:0]           w_lyr_rd [pLayerNum];

    assign w_blk_hit   = (iSUsiAdrs[c_SEL_MSB:pCsrAdrsWidth] == c_BLK_SEL);
    assign w_ofs       = iSUsiAdrs[pCsrAdrsWidth-1:0];
    assign w_wr        = iSUsiWCke && w_blk_hit;
    assign w_wr_ctrl   = w_wr && (w_ofs == c_CTRL);
    assign w_wr_status = w_wr && (w_ofs == c_STATUS);
    assign w_wr_irqen  = w_wr && (w_ofs == c_IRQEN);

    // Commit FSM: state register
    always_ff @(posedge iSysClk) begin
        if (iSysRst) r_state <= c_S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Commit FSM: next state; a COMMIT on a frame-start cycle only arms it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_wr_ctrl && iSUsiWd[0]) w_state_nxt = c_S_PENDING;
            c_S_PENDING: if (iFrameStart)             w_state_nxt = c_S_IDLE;
            default:                                  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Commit FSM: outputs
    always_comb begin
        w_pending = (r_state == c_S_PENDING);
        w_commit  = (r_state == c_S_PENDING) && iFrameStart;
    end

    always_comb begin
        w_st_set                 = '0;
        w_st_set[c_ST_FRAME]     = iFrameStart;
        w_st_set[c_ST_COMMITTED] = w_commit;
        w_st_set[c_ST_UNDERFLOW] = iUnderflow;
        w_st_clr                 = w_wr_status ? iSUsiWd[c_ST_WIDTH-1:0] : '0;
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_status <= '0;
            r_irqen  <= '0;
            r_fcnt   <= '0;
            r_irq    <= 1'b0;
        end else begin
            // Hardware set dominates a same-cycle write-1-to-clear
            r_status <= (r_status & ~w_st_clr) | w_st_set;
            if (w_wr_irqen)  r_irqen <= iSUsiWd[c_ST_WIDTH-1:0];
            if (iFrameStart) r_fcnt  <= r_fcnt + 16'd1;
            r_irq <= |(r_status & r_irqen);
        end
    end

    for (genvar g = 0; g < pLayerNum; g++) begin : g_layer
        vtx_layer_regs #(
            .LAYER_IDX    (g),
            .LAYER_NUM    (pLayerNum),
            .MEM_W        (pMemAdrsWidth),
            .CSR_W        (pCsrAdrsWidth),
            .FBUF_DEF_LEN (pFbufDefLen)
        ) u_layer (
            .clk         (iSysClk),
            .rst         (iSysRst),
            .wr_en       (w_wr),
            .offset      (w_ofs),
            .wdata       (iSUsiWd),
            .frame_start (iFrameStart),
            .commit      (w_commit),
            .rd_data     (w_lyr_rd[g]),
            .layer_en    (oLayerEn[g]),
            .layer_adrs  (oLayerAdrs[g*pMemAdrsWidth +: pMemAdrsWidth]),
            .layer_len   (oLayerLen[g*pMemAdrsWidth +: pMemAdrsWidth])
        );
    end

    always_comb begin
        w_rd_glb = '0;
        case (w_ofs)
            c_CTRL:   w_rd_glb[0]              = w_pending;
            c_STATUS: w_rd_glb[c_ST_WIDTH-1:0] = r_status;
            c_IRQEN:  w_rd_glb[c_ST_WIDTH-1:0] = r_irqen;
            c_FCNT:   w_rd_glb[15:0]           = r_fcnt;
            default:  w_rd_glb                 = '0;
        endcase
    end

    always_comb begin
        w_rd_lyr = '0;
        for (int i = 0; i < pLayerNum; i++) w_rd_lyr = w_rd_lyr | w_lyr_rd[i];
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_rd  <= '0;
            r_red <= 1'b0;
        end else begin
            r_rd  <= w_blk_hit ? (w_rd_glb | w_rd_lyr) : '0;
            r_red <= w_blk_hit;
        end
    end

    assign oSUsiRd  = r_rd;
    assign oSUsiREd = r_red;
    assign oIrq     = r_irq;

    if (pBusAdrsBit > c_SEL_MSB + 1) begin : g_unused_adrs
        logic w_unused_adrs;
        assign w_unused_adrs = ^iSUsiAdrs[pBusAdrsBit-1:c_SEL_MSB+1];
    end

endmodule
`default_nettype wire

// File: tb/tb_vtx_layer_csr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vtx_layer_csr
// Description : Self-checking bench for vtx_layer_csr with a register-map
//               level reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vtx_layer_csr;

    localparam int unsigned N    = 2;
    localparam int unsigned W    = 19;
    localparam int unsigned DEF  = 130560;
    localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       wd = '0;
    logic [31:0]       adrs = '0;
    logic              wcke = 1'b0;
    logic [31:0]       rd;
    logic              red;
    logic              fs = 1'b0;
    logic              uf = 1'b0;
    logic [N-1:0]      lay_en;
    logic [N*W-1:0]    lay_adrs;
    logic [N*W-1:0]    lay_len;
    logic              irq;

    int n_assert = 0;
    int n_fail   = 0;

    vtx_layer_csr #(
        .pBlockAdrsMap (8),
        .pAdrsMap      ('h04),
        .pBusAdrsBit   (32),
        .pCsrAdrsWidth (16),
        .pMemAdrsWidth (W),
        .pLayerNum     (N),
        .pFbufDefLen   (DEF)
    ) dut (
        .iSysClk     (clk),
        .iSysRst     (rst),
        .iSUsiWd     (wd),
        .iSUsiAdrs   (adrs),
        .iSUsiWCke   (wcke),
        .oSUsiRd     (rd),
        .oSUsiREd    (red),
        .iFrameStart (fs),
        .iUnderflow  (uf),
        .oLayerEn    (lay_en),
        .oLayerAdrs  (lay_adrs),
        .oLayerLen   (lay_len),
        .oIrq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: register map contents as plain words
    logic [31:0] m_sh  [N][4];
    logic [31:0] m_act [N][4];
    bit          m_sel [N];
    bit          m_pend;
    logic [2:0]  m_status, m_irqen;
    logic [15:0] m_fcnt;
    bit          m_irq, m_red, m_ok;
    logic [31:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int ofs);
        if (ofs == 'h0) return {31'd0, m_pend};
        if (ofs == 'h4) return {29'd0, m_status};
        if (ofs == 'h8) return {29'd0, m_irqen};
        if (ofs == 'hC) return {16'd0, m_fcnt};
        if (ofs >= 'h100 && ofs < 'h100 + 16 * N && (ofs % 4) == 0)
            return m_sh[(ofs - 'h100) / 16][(ofs % 16) / 4];
        return 32'd0;
    endfunction

    task automatic model_update();
        bit          blk, wr, commit;
        int          ofs;
        logic [31:0] rdv;
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                m_sh[n][0] = (n * DEF) & MASK;
                m_sh[n][1] = ((n + N) * DEF) & MASK;
                m_sh[n][2] = (DEF - 1) & MASK;
                m_sh[n][3] = 0;
                for (int r = 0; r < 4; r++) m_act[n][r] = m_sh[n][r];
                m_sel[n] = 0;
            end
            m_pend = 0; m_status = 0; m_irqen = 0; m_fcnt = 0;
            m_irq = 0; m_red = 0; m_rd = 0; m_ok = 1;
        end else if (m_ok) begin
            blk    = (adrs[23:16] == 8'h04);
            ofs    = int'(adrs[15:0]);
            wr     = wcke && blk;
            rdv    = blk ? model_read(ofs) : 32'd0;
            commit = m_pend && fs;
            m_irq  = |(m_status & m_irqen);
            for (int n = 0; n < N; n++) begin
                if (commit) begin
                    for (int r = 0; r < 4; r++) m_act[n][r] = m_sh[n][r];
                    m_sel[n] = 0;
                end else if (fs && m_act[n][3][1:0] == 2'b11) begin
                    m_sel[n] = !m_sel[n];
                end
            end
            if (wr && ofs == 'h4) m_status = m_status & ~wd[2:0];
            m_status = m_status | {uf, commit, fs};
            if (commit) m_pend = 0;
            else if (wr && ofs == 'h0 && wd[0]) m_pend = 1;
            if (wr && ofs == 'h8) m_irqen = wd[2:0];
            if (fs) m_fcnt = m_fcnt + 16'd1;
            if (wr && ofs >= 'h100 && ofs < 'h100 + 16 * N && (ofs % 4) == 0)
                m_sh[(ofs - 'h100) / 16][(ofs % 16) / 4] =
                    ((ofs % 16) == 12) ? (wd & 32'd3) : (wd & MASK);
            m_rd  = rdv;
            m_red = blk;
        end
    endtask

    task automatic compare_all();
        if (!m_ok) return;
        for (int n = 0; n < N; n++) begin
            check($sformatf("model_en%0d", n), {31'd0, lay_en[n]}, {31'd0, m_act[n][3][0]});
            check($sformatf("model_adrs%0d", n), 32'(lay_adrs[n*W +: W]),
                  m_sel[n] ? m_act[n][1] : m_act[n][0]);
            check($sformatf("model_len%0d", n), 32'(lay_len[n*W +: W]), m_act[n][2]);
        end
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        check("model_red", {31'd0, red}, {31'd0, m_red});
        check("model_rd", rd, m_rd);
    endtask

    // One clock: compare previous-edge outputs, advance model, then idle inputs
    task automatic step();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #2;
        wcke = 1'b0; adrs = 32'h0; wd = '0; fs = 1'b0; uf = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [15:0] ofs);
        return {8'h00, 8'h04, ofs};
    endfunction

    task automatic wr(input logic [15:0] ofs, input logic [31:0] data);
        adrs = mk(ofs); wd = data; wcke = 1'b1;
        step();
    endtask

    task automatic rd_chk(input string name, input logic [15:0] ofs, input logic [31:0] exp);
        adrs = mk(ofs);
        step();
        check(name, rd, exp);
        check({name, "_red"}, {31'd0, red}, 32'd1);
    endtask

    function automatic logic [31:0] adrs0();
        return 32'(lay_adrs[W-1:0]);
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_en", {30'd0, lay_en}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_red", {31'd0, red}, 32'd0);
        check("rst_adrs1", 32'(lay_adrs[2*W-1:W]), 32'h0001FE00);

        rd_chk("rst_adrsb0", 16'h104, 32'h0003FC00);
        step();
        check("red_one_cycle", {31'd0, red}, 32'd0);
        rd_chk("rst_len0", 16'h108, 32'h0001FDFF);
        rd_chk("rst_adrsa1", 16'h110, 32'h0001FE00);

        wr(16'h100, 32'h1000);
        wr(16'h10C, 32'h1);
        wr(16'h000, 32'h1);
        rd_chk("ctrl_pending", 16'h000, 32'h1);
        check("adrs_before_commit", adrs0(), 32'h0);
        fs = 1'b1; step();
        check("adrs_after_commit", adrs0(), 32'h1000);
        check("en_after_commit", {30'd0, lay_en}, 32'h1);
        rd_chk("status_commit", 16'h004, 32'h3);
        rd_chk("ctrl_cleared", 16'h000, 32'h0);

        wr(16'h004, 32'h7);
        wr(16'h104, 32'h3000);
        wr(16'h10C, 32'h3);
        wr(16'h000, 32'h1);
        fs = 1'b1; step();
        check("swap_0", adrs0(), 32'h1000);
        fs = 1'b1; step();
        check("swap_1", adrs0(), 32'h3000);
        fs = 1'b1; step();
        check("swap_2", adrs0(), 32'h1000);
        fs = 1'b1; step();
        check("swap_3", adrs0(), 32'h3000);

        wr(16'h100, 32'h5000);
        adrs = mk(16'h000); wd = 32'h1; wcke = 1'b1; fs = 1'b1;
        step();
        check("commit_on_fs_nocommit", adrs0(), 32'h1000);
        rd_chk("commit_on_fs_pending", 16'h000, 32'h1);
        adrs = mk(16'h100); wd = 32'h7000; wcke = 1'b1; fs = 1'b1;
        step();
        check("commit_next_fs", adrs0(), 32'h5000);
        rd_chk("shadow_after_commit", 16'h100, 32'h7000);

        wr(16'h004, 32'h7);
        wr(16'h008, 32'h4);
        uf = 1'b1; step();
        check("irq_lag", {31'd0, irq}, 32'd0);
        step();
        check("irq_set", {31'd0, irq}, 32'd1);
        adrs = mk(16'h004); wd = 32'h4; wcke = 1'b1; uf = 1'b1;
        step();
        rd_chk("status_set_wins", 16'h004, 32'h4);
        check("irq_held", {31'd0, irq}, 32'd1);
        wr(16'h004, 32'h4);
        step();
        check("irq_cleared", {31'd0, irq}, 32'd0);

        rst = 1'b1; step();
        rst = 1'b0;
        rd_chk("rst_discard_shadow", 16'h100, 32'h0);
        rd_chk("rst_discard_lctrl", 16'h10C, 32'h0);
        check("rst_discard_adrs", adrs0(), 32'h0);
        for (int i = 0; i < 65535; i++) begin
            fs = 1'b1; step();
        end
        rd_chk("fcnt_max", 16'h00C, 32'h0000FFFF);
        fs = 1'b1; step();
        rd_chk("fcnt_wrap", 16'h00C, 32'h0);

        rd_chk("oob_layer", 16'h1F0, 32'h0);
        wr(16'h1F0, 32'hFFFFFFFF);
        rd_chk("oob_layer_wr", 16'h1F0, 32'h0);
        rd_chk("unmapped", 16'h010, 32'h0);
        rd_chk("layer1_intact", 16'h110, 32'h0001FE00);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
